// File: rtl/aes_mode_pkg.sv
// Shared codes for the AES mode-of-operation controller: block width, mode codes, FSM states.
package aes_mode_pkg;

    localparam int BLK_W = 128;

    localparam logic [1:0] MODE_ECB  = 2'd0;
    localparam logic [1:0] MODE_CBC  = 2'd1;
    localparam logic [1:0] MODE_CTR  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IN   = 3'd1,
        ST_CORE_REQ  = 3'd2,
        ST_CORE_WAIT = 3'd3,
        ST_OUT       = 3'd4,
        ST_FIN       = 3'd5
    } state_e;

endpackage

// File: rtl/aes_mode_datapath.sv
// Chain/P registers and per-mode muxing around the AES core for aes_mode_ctrl.
// CTR chaining is compiled in only when AES_MODE_CTR_EN is defined.
module aes_mode_datapath
    import aes_mode_pkg::*;
#(
    parameter int CTR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load_i,
    input  logic [BLK_W-1:0] iv_i,
    input  logic             in_load_i,
    input  logic [BLK_W-1:0] s_data_i,
    input  logic             res_load_i,
    input  logic [BLK_W-1:0] core_result_i,
    input  logic [1:0]       mode_i,
    input  logic             encrypt_i,
    output logic [BLK_W-1:0] core_data_o,
    output logic             core_encrypt_o,
    output logic [BLK_W-1:0] m_data_o
);

    logic [BLK_W-1:0] chain_q, chain_d;
    logic [BLK_W-1:0] p_q;
    logic [BLK_W-1:0] m_data_q, m_data_d;

`ifdef AES_MODE_CTR_EN
    // Only the low CTR_W bits count; the upper counter-block bits never see a carry.
    localparam logic [BLK_W-1:0] CTR_MASK = {BLK_W{1'b1}} >> (BLK_W - CTR_W);
`else
    logic unused_ctr_w;
    assign unused_ctr_w = (CTR_W > 0);
`endif

    always_comb begin
        core_data_o    = p_q;
        core_encrypt_o = encrypt_i;
        m_data_d       = core_result_i;
        chain_d        = chain_q;
        case (mode_i)
            MODE_ECB: ;
            MODE_CBC: begin
                if (encrypt_i) begin
                    core_data_o = p_q ^ chain_q;
                    chain_d     = core_result_i;
                end else begin
                    m_data_d = core_result_i ^ chain_q;
                    chain_d  = p_q;
                end
            end
`ifdef AES_MODE_CTR_EN
            MODE_CTR: begin
                core_data_o    = chain_q;
                core_encrypt_o = 1'b1;
                m_data_d       = core_result_i ^ p_q;
                chain_d        = (chain_q & ~CTR_MASK) | ((chain_q + BLK_W'(1)) & CTR_MASK);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q  <= '0;
            p_q      <= '0;
            m_data_q <= '0;
        end else begin
            if (cfg_load_i)
                chain_q <= iv_i;
            else if (res_load_i)
                chain_q <= chain_d;
            if (in_load_i)
                p_q <= s_data_i;
            if (res_load_i)
                m_data_q <= m_data_d;
        end
    end

    assign m_data_o = m_data_q;

endmodule

// File: rtl/aes_mode_ctrl.sv
// Streams N blocks through an external start/done AES core with ECB/CBC/CTR chaining.
// AES_MODE_CTR_EN enables CTR mode; without it mode 2 is rejected like mode 3.
module aes_mode_ctrl
    import aes_mode_pkg::*;
#(
    parameter int CTR_W = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             encrypt,
    input  logic [BLK_W-1:0] key_in,
    input  logic [BLK_W-1:0] iv_in,
    input  logic [LEN_W-1:0] num_blocks,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BLK_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_W-1:0] m_data,
    output logic             m_last,
    output logic             core_start,
    output logic             core_encrypt,
    output logic [BLK_W-1:0] core_data,
    output logic [BLK_W-1:0] core_key,
    input  logic [BLK_W-1:0] core_result,
    input  logic             core_done,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [LEN_W-1:0] blk_cnt
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q;
    logic             enc_q;
    logic [BLK_W-1:0] key_q;
    logic [LEN_W-1:0] nblk_q, blk_cnt_q;
    logic             m_valid_q, m_last_q, cfg_err_q;
    logic             cfg_load, in_load, res_load, out_fire, is_last, bad_mode;

`ifdef AES_MODE_CTR_EN
    assign bad_mode = (mode == MODE_RSVD);
`else
    assign bad_mode = (mode == MODE_RSVD) || (mode == MODE_CTR);
`endif

    assign cfg_load = (state_q == ST_IDLE) && start;
    assign in_load  = (state_q == ST_WAIT_IN) && s_valid;
    assign res_load = (state_q == ST_CORE_WAIT) && core_done;
    assign out_fire = (state_q == ST_OUT) && m_ready;
    assign is_last  = ((blk_cnt_q + LEN_W'(1)) == nblk_q);

    always_comb begin
        state_d    = state_q;
        s_ready    = 1'b0;
        core_start = 1'b0;
        done       = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start && !bad_mode)
                    state_d = (num_blocks == '0) ? ST_FIN : ST_WAIT_IN;
            end
            ST_WAIT_IN: begin
                s_ready = 1'b1;
                if (s_valid)
                    state_d = ST_CORE_REQ;
            end
            ST_CORE_REQ: begin
                core_start = 1'b1;
                state_d    = ST_CORE_WAIT;
            end
            ST_CORE_WAIT: begin
                if (core_done)
                    state_d = ST_OUT;
            end
            ST_OUT: begin
                // m_last_q was captured with the same blk_cnt, so it doubles as the exit test.
                if (m_ready)
                    state_d = m_last_q ? ST_FIN : ST_WAIT_IN;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ECB;
            enc_q     <= 1'b0;
            key_q     <= '0;
            nblk_q    <= '0;
            blk_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_load && bad_mode;
            if (cfg_load) begin
                mode_q    <= mode;
                enc_q     <= encrypt;
                key_q     <= key_in;
                nblk_q    <= num_blocks;
                blk_cnt_q <= '0;
            end else if (out_fire) begin
                blk_cnt_q <= blk_cnt_q + LEN_W'(1);
            end
            if (res_load) begin
                m_valid_q <= 1'b1;
                m_last_q  <= is_last;
            end else if (out_fire) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

    aes_mode_datapath #(.CTR_W(CTR_W)) u_dp (
        .clk           (clk),
        .rst           (rst),
        .cfg_load_i    (cfg_load),
        .iv_i          (iv_in),
        .in_load_i     (in_load),
        .s_data_i      (s_data),
        .res_load_i    (res_load),
        .core_result_i (core_result),
        .mode_i        (mode_q),
        .encrypt_i     (enc_q),
        .core_data_o   (core_data),
        .core_encrypt_o(core_encrypt),
        .m_data_o      (m_data)
    );

    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign cfg_err  = cfg_err_q;
    assign core_key = key_q;
    assign blk_cnt  = blk_cnt_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl: table of NIST-style vectors through a lookup-table core model,
// scoreboarded outputs, plus hand sequences for stall, cfg errors, empty messages and reset.
module tb_aes_mode_ctrl;

    localparam int CTR_W = 32;
    localparam int LEN_W = 16;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         encrypt = 1'b0;
    logic [127:0] key_in = KEY;
    logic [127:0] iv_in = '0;
    logic [LEN_W-1:0] num_blocks = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [127:0] m_data;
    logic         m_last;
    logic         core_start, core_encrypt;
    logic [127:0] core_data, core_key;
    logic [127:0] core_result = '0;
    logic         core_done = 1'b0;
    logic         busy, done, cfg_err;
    logic [LEN_W-1:0] blk_cnt;

    aes_mode_ctrl #(.CTR_W(CTR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .encrypt(encrypt),
        .key_in(key_in), .iv_in(iv_in), .num_blocks(num_blocks),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_start(core_start), .core_encrypt(core_encrypt), .core_data(core_data),
        .core_key(core_key), .core_result(core_result), .core_done(core_done),
        .busy(busy), .done(done), .cfg_err(cfg_err), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Known AES-128 pairs under KEY; anything else uses an invertible stand-in cipher.
    function automatic logic [127:0] fwd(input logic [127:0] d, input logic [127:0] k);
        case (d)
            128'h6bc1bee22e409f96e93d7e117393172a: return 128'h3ad77bb40d7a3660a89ecaf32466ef97;
            128'h6bc0bce12a459991e134741a7f9e1925: return 128'h7649abac8119b246cee98e9b12e9197d;
            128'hd86421fb9f1a1eda505ee1375746972c: return 128'h5086cb9b507219ee95db113a917678b2;
            128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff: return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
            128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00: return 128'h362b7c3c6773516318a077d7fc5073ae;
            default: return {d[63:0], d[127:64]} ^ k;
        endcase
    endfunction

    function automatic logic [127:0] inv(input logic [127:0] d, input logic [127:0] k);
        logic [127:0] x;
        x = d ^ k;
        case (d)
            128'h3ad77bb40d7a3660a89ecaf32466ef97: return 128'h6bc1bee22e409f96e93d7e117393172a;
            128'h7649abac8119b246cee98e9b12e9197d: return 128'h6bc0bce12a459991e134741a7f9e1925;
            128'h5086cb9b507219ee95db113a917678b2: return 128'hd86421fb9f1a1eda505ee1375746972c;
            default: return {x[63:0], x[127:64]};
        endcase
    endfunction

    // Core model: fixed 3-cycle latency, logs every request it sees.
    logic [256:0] core_log[$];
    int           core_cnt = 0;
    logic [127:0] core_pend = '0;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_done   <= 1'b1;
                core_result <= core_pend;
            end
        end
        if (core_start) begin
            core_log.push_back({core_encrypt, core_key, core_data});
            core_pend <= core_encrypt ? fwd(core_data, core_key) : inv(core_data, core_key);
            core_cnt  <= 3;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string        nm;
        logic [1:0]   md;
        logic         enc;
        logic [127:0] iv;
        int           n;
        logic [127:0] pt0, pt1, ct0, ct1, cd0, cd1;
        int           stall;
        bit           poke;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [1:0] md, input logic enc,
                                input logic [127:0] iv, input int n,
                                input logic [127:0] pt0, pt1, ct0, ct1, cd0, cd1,
                                input int stall, input bit poke);
        vec_t v;
        v.nm = nm; v.md = md; v.enc = enc; v.iv = iv; v.n = n;
        v.pt0 = pt0; v.pt1 = pt1; v.ct0 = ct0; v.ct1 = ct1; v.cd0 = cd0; v.cd1 = cd1;
        v.stall = stall; v.poke = poke;
        return v;
    endfunction

    logic [128:0] exp_q[$];

    task automatic run_vec(input vec_t v);
        logic [127:0] pt, cd;
        logic [256:0] lg;
        logic [128:0] ex;
        logic         last, seen;
        int           w;
        mode = v.md; encrypt = v.enc; iv_in = v.iv; num_blocks = LEN_W'(v.n); start = 1'b1;
        tick();
        start = 1'b0;
        if (v.poke) begin
            start = 1'b1; mode = 2'd3; num_blocks = '0;
            tick();
            start = 1'b0; mode = v.md;
            chk({v.nm, "_busy_start_sready"}, 128'(s_ready), 128'd1);
            chk({v.nm, "_busy_start_cfgerr"}, 128'(cfg_err), 128'd0);
        end
        for (int b = 0; b < v.n; b++) begin
            pt   = (b == 0) ? v.pt0 : v.pt1;
            cd   = (b == 0) ? v.cd0 : v.cd1;
            last = (b == v.n - 1);
            w = 0;
            while (!s_ready && w < 20) begin tick(); w++; end
            chk({v.nm, "_s_ready"}, 128'(s_ready), 128'd1);
            if (!s_ready) break;
            s_valid = 1'b1; s_data = pt;
            exp_q.push_back({last, (b == 0) ? v.ct0 : v.ct1});
            tick();
            s_valid = 1'b0; s_data = '0;
            chk({v.nm, "_core_start_t1"}, 128'(core_start), 128'd1);
            w = 0; seen = core_done;
            while (!seen && w < 20) begin tick(); w++; seen = core_done; end
            chk({v.nm, "_core_done_seen"}, 128'(seen), 128'd1);
            tick();
            chk({v.nm, "_m_valid_u1"}, 128'(m_valid), 128'd1);
            chk({v.nm, "_core_req_count"}, 128'(core_log.size()), 128'd1);
            lg = (core_log.size() > 0) ? core_log.pop_front() : '0;
            chk({v.nm, "_core_data"}, lg[127:0], cd);
            chk({v.nm, "_core_key"}, lg[255:128], KEY);
            chk({v.nm, "_core_encrypt"}, 128'(lg[256]), 128'((v.md == 2'd2) ? 1'b1 : v.enc));
            ex = exp_q.pop_front();
            for (int s = 0; s < v.stall; s++) begin
                chk({v.nm, "_stall_m_data"}, m_data, ex[127:0]);
                chk({v.nm, "_stall_s_ready"}, 128'(s_ready), 128'd0);
                tick();
            end
            chk({v.nm, "_m_data"}, m_data, ex[127:0]);
            chk({v.nm, "_m_last"}, 128'(m_last), 128'(ex[128]));
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            if (last) chk({v.nm, "_done_u2"}, 128'(done), 128'd1);
            else      chk({v.nm, "_s_ready_u2"}, 128'(s_ready), 128'd1);
        end
        chk({v.nm, "_blk_cnt"}, 128'(blk_cnt), 128'(v.n));
        tick();
        chk({v.nm, "_busy_u3"}, 128'(busy), 128'd0);
        chk({v.nm, "_done_pulse"}, 128'(done), 128'd0);
    endtask

    task automatic bad_mode_seq(input string nm, input logic [1:0] md);
        mode = md; num_blocks = LEN_W'(1); start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, "_cfg_err"}, 128'(cfg_err), 128'd1);
        chk({nm, "_busy"}, 128'(busy), 128'd0);
        tick();
        chk({nm, "_cfg_err_pulse"}, 128'(cfg_err), 128'd0);
        chk({nm, "_idle"}, 128'({busy, s_ready}), 128'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, 128'({s_ready, m_valid, m_last, core_start, core_encrypt, busy, done, cfg_err}), 128'd0);
        chk({nm, "_m_data"}, m_data, 128'd0);
        chk({nm, "_core_data"}, core_data, 128'd0);
        chk({nm, "_core_key"}, core_key, 128'd0);
        chk({nm, "_blk_cnt"}, 128'(blk_cnt), 128'd0);
    endtask

    vec_t vt[$];
    logic [127:0] wiv, wcd1, rp;
    int           bad;
    logic         seen_late;

    initial begin
        #2 rst = 1'b1;
        #1;
        chk_all_zero("reset");
        tick(); tick();
        rst = 1'b0;
        tick();

        vt.push_back(mk("ecb_enc", 2'd0, 1'b1, '0, 1,
            128'h6bc1bee22e409f96e93d7e117393172a, '0,
            128'h3ad77bb40d7a3660a89ecaf32466ef97, '0,
            128'h6bc1bee22e409f96e93d7e117393172a, '0, 0, 1'b0));
        vt.push_back(mk("cbc_enc", 2'd1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 2,
            128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
            128'h7649abac8119b246cee98e9b12e9197d, 128'h5086cb9b507219ee95db113a917678b2,
            128'h6bc0bce12a459991e134741a7f9e1925, 128'hd86421fb9f1a1eda505ee1375746972c, 5, 1'b0));
        vt.push_back(mk("cbc_dec", 2'd1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 2,
            128'h7649abac8119b246cee98e9b12e9197d, 128'h5086cb9b507219ee95db113a917678b2,
            128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
            128'h7649abac8119b246cee98e9b12e9197d, 128'h5086cb9b507219ee95db113a917678b2, 0, 1'b0));
        vt.push_back(mk("ecb_dec", 2'd0, 1'b0, '0, 1,
            128'h3ad77bb40d7a3660a89ecaf32466ef97, '0,
            128'h6bc1bee22e409f96e93d7e117393172a, '0,
            128'h3ad77bb40d7a3660a89ecaf32466ef97, '0, 0, 1'b1));
`ifdef AES_MODE_CTR_EN
        vt.push_back(mk("ctr", 2'd2, 1'b0, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 2,
            128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
            128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff,
            128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00, 0, 1'b0));
        wiv  = 128'h0123456789abcdef01234567ffffffff;
        wcd1 = 128'h0123456789abcdef0123456700000000;
        vt.push_back(mk("ctr_wrap", 2'd2, 1'b1, wiv, 2,
            128'h1111111111111111aaaaaaaaaaaaaaaa, 128'h22222222222222225555555555555555,
            fwd(wiv, KEY) ^ 128'h1111111111111111aaaaaaaaaaaaaaaa,
            fwd(wcd1, KEY) ^ 128'h22222222222222225555555555555555,
            wiv, wcd1, 0, 1'b0));
`endif
        foreach (vt[i]) run_vec(vt[i]);

        bad_mode_seq("mode3", 2'd3);
`ifndef AES_MODE_CTR_EN
        bad_mode_seq("mode2_disabled", 2'd2);
`endif

        // Empty message: done one cycle after start, no stream or core traffic.
        mode = 2'd0; num_blocks = '0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("nblk0_done_t1", 128'({done, busy, s_ready}), 128'b110);
        tick();
        chk("nblk0_idle_t2", 128'({done, busy}), 128'd0);
        chk("nblk0_no_core", 128'(core_log.size()), 128'd0);

        // Reset while the core is working; its late done must be dropped.
        rp = 128'h00112233445566778899aabbccddeeff;
        mode = 2'd0; encrypt = 1'b1; num_blocks = LEN_W'(1); start = 1'b1;
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = rp;
        tick();
        s_valid = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        chk_all_zero("rst_core_wait");
        tick();
        rst = 1'b0;
        bad = 0; seen_late = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (core_done) seen_late = 1'b1;
            if (m_valid || busy) bad++;
            tick();
        end
        chk("rst_late_done_arrived", 128'(seen_late), 128'd1);
        chk("rst_late_done_ignored", 128'(bad), 128'd0);
        core_log.delete();
        run_vec(mk("post_rst_ecb", 2'd0, 1'b1, '0, 1, rp, '0, fwd(rp, KEY), '0, rp, '0, 0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
